// File: rtl/fieldious_io_pkg.sv
// Shared types for the fieldious narrow I/O path: slice width, fetch ratio and
// the disaggregator FSM encoding. Also consumed by aggregator.
package fieldious_io_pkg;

  localparam int unsigned DSIZE       = 11;
  localparam int unsigned FETCH_WIDTH = 2;

  typedef logic [DSIZE-1:0] slice_t;

  typedef enum logic [0:0] {
    EMPTY,
    STREAM
  } disagg_state_e;

endpackage

// File: rtl/result_disaggregator.sv
// Wide-to-narrow serializer: pops FETCH_WIDTH*DATA_WIDTH words from a show-ahead
// FIFO and pushes them LSB slice first into a narrow FIFO at one slice per cycle.
module result_disaggregator
  import fieldious_io_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 11,
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             wrst_n,
  input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data,
  input  logic                             sender_empty_n,
  output logic                             sender_deq,
  output logic [DATA_WIDTH-1:0]            receiver_data,
  input  logic                             receiver_full_n,
  output logic                             receiver_enq,
  output logic                             receiver_last,
  output logic                             busy,
  output logic [COUNT_WIDTH-1:0]           word_count
);

  localparam int unsigned WordWidth = FETCH_WIDTH * DATA_WIDTH;
  localparam int unsigned IdxWidth  = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(FETCH_WIDTH - 1);

  disagg_state_e          r_state, w_state_d;
  logic [WordWidth-1:0]   r_sreg, w_sreg_d;
  logic [IdxWidth-1:0]    r_idx, w_idx_d;
  logic [COUNT_WIDTH-1:0] r_count, w_count_d;

  logic w_last;
  logic w_enq;
  logic w_done;
  logic w_deq;

  always_comb begin
    w_last = (r_state == STREAM) && (r_idx == LastIdx);
    w_enq  = wrst_n && (r_state == STREAM) && receiver_full_n;
    w_done = w_enq && w_last;
    // Refill in the same cycle the last slice leaves, so words stream with no bubble.
    w_deq  = wrst_n && sender_empty_n && ((r_state == EMPTY) || w_done);
  end

  always_comb begin
    w_state_d = r_state;
    w_sreg_d  = r_sreg;
    w_idx_d   = r_idx;
    w_count_d = r_count;

    if (w_deq) begin
      w_state_d = STREAM;
      w_sreg_d  = sender_data;
      w_idx_d   = '0;
    end else if (w_done) begin
      w_state_d = EMPTY;
    end else if (w_enq) begin
      w_sreg_d = r_sreg >> DATA_WIDTH;
      w_idx_d  = r_idx + IdxWidth'(1);
    end

    if (w_done) begin
      w_count_d = r_count + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!wrst_n) begin
      r_state <= EMPTY;
      r_sreg  <= '0;
      r_idx   <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_d;
      r_sreg  <= w_sreg_d;
      r_idx   <= w_idx_d;
      r_count <= w_count_d;
    end
  end

  assign sender_deq    = w_deq;
  assign receiver_enq  = w_enq;
  assign receiver_last = w_last;
  assign receiver_data = r_sreg[DATA_WIDTH-1:0];
  assign busy          = (r_state == STREAM);
  assign word_count    = r_count;

endmodule
